// File: rtl/sigdel_pkg.sv
// Shared constants and types for the sigma-delta modulator slice.
package sigdel_pkg;

    localparam int SIGDEL_W     = 16;
    localparam int SIGDEL_DEPTH = 8;

    typedef logic [SIGDEL_W-1:0] sigdel_sample_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sigdel_fifo.sv
// Synchronous sample FIFO; the read register only updates on a pop, so it
// doubles as the modulator's held sample.
module sigdel_fifo
    import sigdel_pkg::*;
#(
    parameter int W     = SIGDEL_W,
    parameter int DEPTH = SIGDEL_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head_data,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [W-1:0]  head_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_reg == FULL_LEVEL);
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pop reads pre-edge contents only, so a same-cycle push is never bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                head_reg   <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head_data = head_reg;
    assign level     = level_reg;

endmodule

// File: rtl/sigdel_modulator.sv
// First-order sigma-delta DAC modulator fed from a sample FIFO.
// Optional saturating underrun counter enabled by SIGDEL_UNDERRUN_CNT_EN.
module sigdel_modulator
    import sigdel_pkg::*;
#(
    parameter int W     = SIGDEL_W,
    parameter int DEPTH = SIGDEL_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          sample_strobe,
    input  logic [W-1:0]                  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic                          dac_out,
    output logic                          underrun
`ifdef SIGDEL_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);

    logic [W-1:0] cur_sample;
    logic [W-1:0] acc_reg;
    logic [W:0]   sum;
    logic         dac_reg;
    logic         underrun_reg;
    logic         underrun_next;
    logic         strobe_act;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;

    assign in_ready      = !fifo_full;
    assign push          = in_valid && in_ready;
    assign strobe_act    = ena && sample_strobe;
    assign pop           = strobe_act && !fifo_empty;
    assign underrun_next = strobe_act && fifo_empty;

    sigdel_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head_data (cur_sample),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Carry out of the accumulator is the output bit.
    assign sum = {1'b0, acc_reg} + {1'b0, cur_sample};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            dac_reg      <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= underrun_next;
            if (ena) begin
                acc_reg <= sum[W-1:0];
                dac_reg <= sum[W];
            end
        end
    end

    assign dac_out  = dac_reg;
    assign underrun = underrun_reg;

`ifdef SIGDEL_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_count_reg <= '0;
        end else if (underrun_next && underrun_count_reg != 16'hFFFF) begin
            underrun_count_reg <= underrun_count_reg + 16'd1;
        end
    end

    assign underrun_count = underrun_count_reg;
`endif

endmodule

// File: tb/tb_sigdel_modulator.sv
// Directed self-checking bench for sigdel_modulator (W=8, DEPTH=8).
module tb_sigdel_modulator;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         sample_strobe = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   fifo_level;
    logic         dac_out;
    logic         underrun;
`ifdef SIGDEL_UNDERRUN_CNT_EN
    logic [15:0]  underrun_count;
`endif

    int total = 0;
    int bad   = 0;
    int ones;

    sigdel_modulator #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .sample_strobe (sample_strobe),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fifo_level    (fifo_level),
        .dac_out       (dac_out),
        .underrun      (underrun)
`ifdef SIGDEL_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic strobe1();
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
    endtask

    // Ones over the 256 bits starting with the first bit driven by the new sample.
    task automatic measure(output int n);
        n = 0;
        repeat (256) begin
            step();
            n += int'(dac_out);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        ena = 1'b1;
        step();
        step();
        check("reset_dac", dac_out, 0);
        check("reset_underrun", underrun, 0);
        check("reset_level", fifo_level, 0);
        check("reset_ready", in_ready, 1);
`ifdef SIGDEL_UNDERRUN_CNT_EN
        check("reset_count", underrun_count, 0);
`endif
        rst = 1'b0;

        // Fill to full: 0x09 must be refused
        for (int v = 1; v <= 9; v++) begin
            in_valid = 1'b1;
            in_data  = 8'(v);
            step();
        end
        in_valid = 1'b0;
        check("full_level", fifo_level, 8);
        check("full_ready", in_ready, 0);
        for (int k = 1; k <= 8; k++) begin
            strobe1();
            measure(ones);
            check("pop_order_density", ones, k);
        end
        check("drained_level", fifo_level, 0);
        check("no_spurious_underrun", underrun, 0);

        // Density
        push1(8'h40);
        strobe1();
        measure(ones);
        check("density_40", ones, 64);
        push1(8'h00);
        strobe1();
        measure(ones);
        check("density_00", ones, 0);
        push1(8'hFF);
        strobe1();
        measure(ones);
        check("density_ff", ones, 255);

        // Underrun with cur_sample = 0x80
        push1(8'h80);
        strobe1();
        measure(ones);
        check("density_80", ones, 128);
        strobe1();
        check("underrun_pulse", underrun, 1);
        step();
        check("underrun_one_cycle", underrun, 0);
        measure(ones);
        check("underrun_holds_sample", ones, 128);
`ifdef SIGDEL_UNDERRUN_CNT_EN
        check("underrun_count_1", underrun_count, 1);
`endif

        // Simultaneous push and pop at level 3
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        check("level_3", fifo_level, 3);
        in_valid      = 1'b1;
        in_data       = 8'h44;
        sample_strobe = 1'b1;
        step();
        in_valid      = 1'b0;
        sample_strobe = 1'b0;
        check("pushpop_level", fifo_level, 3);
        measure(ones);
        check("pushpop_order_11", ones, 8'h11);
        strobe1();
        measure(ones);
        check("pushpop_order_22", ones, 8'h22);
        strobe1();
        measure(ones);
        check("pushpop_order_33", ones, 8'h33);
        strobe1();
        measure(ones);
        check("pushpop_order_44", ones, 8'h44);
        check("pushpop_empty", fifo_level, 0);

        // Mid-run reset with five samples queued
        for (int v = 1; v <= 5; v++) push1(8'(v * 16));
        check("level_5", fifo_level, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_level", fifo_level, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_dac", dac_out, 0);
        check("midrst_underrun", underrun, 0);
`ifdef SIGDEL_UNDERRUN_CNT_EN
        check("midrst_count", underrun_count, 0);
`endif
        strobe1();
        check("midrst_first_strobe_underrun", underrun, 1);
        // acc cleared: 0x80 from acc=0 gives 0,1,0,1...
        push1(8'h80);
        strobe1();
        step();
        check("acc_zero_bit0", dac_out, 0);
        step();
        check("acc_zero_bit1", dac_out, 1);

        // Freeze: ena=0 strobes neither pop nor underrun, dac holds
        ena = 1'b0;
        strobe1();
        check("frozen_no_underrun", underrun, 0);
        check("frozen_dac_a", dac_out, 1);
        push1(8'h20);
        check("frozen_push_level", fifo_level, 1);
        strobe1();
        check("frozen_no_pop", fifo_level, 1);
        check("frozen_no_underrun2", underrun, 0);
        check("frozen_dac_b", dac_out, 1);
        ena = 1'b1;
        step();
        check("resume_dac", dac_out, 0);
        strobe1();
        check("resume_pop_dac", dac_out, 1);
        check("resume_pop_level", fifo_level, 0);
`ifdef SIGDEL_UNDERRUN_CNT_EN
        check("count_after_freeze", underrun_count, 1);

        // Saturation
        sample_strobe = 1'b1;
        repeat (70000) step();
        sample_strobe = 1'b0;
        step();
        check("count_saturated", underrun_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigdel_modulator.md
# sigdel_modulator

First-order sigma-delta modulator with a sample FIFO on its input. It sits directly downstream of the periodic pulse generator: each one-cycle strobe from that generator pops one sample from the FIFO into the modulator's held-sample register. Every enabled clock, the modulator emits one bit of the 1-bit DAC bitstream. The ones-density of `dac_out` equals `cur_sample / 2^W`.

## Interface
- `W`, 16: sample width. Samples are unsigned offset-binary.
- `DEPTH`, 8: FIFO depth. Must be a power of two and ≥ 2.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `ena` input 1: global clock enable for the modulator and the pop path.
- `sample_strobe` input 1: one-cycle sample-rate pulse from the pulse generator.
- `in_data` input W: sample to push.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: FIFO can accept a push.
- `fifo_level` output $clog2(DEPTH)+1: number of stored samples.
- `dac_out` output 1: modulator bitstream.
- `underrun` output 1: one-cycle pulse when a strobe finds the FIFO empty.
- `underrun_count` output 16: present only with `SIGDEL_UNDERRUN_CNT_EN`.

## Operation
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (fifo_level != DEPTH)`, decoded from registered state. Push is independent of `ena`.
- **Pop condition:** `ena && sample_strobe && fifo_level != 0`. The head sample loads into `cur_sample`.
- **Pop source:** pop uses only the pre-edge contents. There is no bypass, so a sample pushed in cycle t can be popped at the earliest in cycle t+1.
- **Underrun:** occurs on `ena && sample_strobe && fifo_level == 0`. `cur_sample` holds its previous value and `underrun` = 1 for exactly one cycle.
- **Ignored strobes:** a strobe with `ena` = 0 is ignored and does not count as an underrun.
- **Simultaneous push and pop:** `fifo_level` is unchanged and FIFO order is preserved.
- **Push when full:** not possible, because `in_ready` = 0. `in_data` is ignored.
- **Modulator:** keeps a W-bit accumulator `acc`. Each cycle with `ena` = 1 it computes the W+1-bit sum `sum = acc + cur_sample`, then sets `dac_out <= sum[W]` and `acc <= sum[W-1:0]`.
- **Freeze:** with `ena` = 0, `acc`, `dac_out` and `cur_sample` hold.
- **Extremes:**
  - `cur_sample` = 0 gives `dac_out` permanently 0.
  - `cur_sample` = 2^W-1 gives 2^W-1 ones per 2^W cycles.
- **Pointer wrap:** FIFO pointers are $clog2(DEPTH) bits and wrap naturally. `fifo_level` is tracked separately.
- **Reset values:**
  - `acc` = 0, `cur_sample` = 0.
  - `dac_out` = 0, `underrun` = 0.
  - FIFO empty, so `fifo_level` = 0 and `in_ready` = 1.
  - `underrun_count` = 0.
- **Reset mid-operation:** flushes all stored samples and returns every output to its reset value on the next edge.

## Timing
- **Push latency:** `fifo_level` reflects a push at the edge that accepts it.
- **Strobe to output:** a strobe in cycle t loads `cur_sample` at edge t. The first `dac_out` bit influenced by the new sample appears after edge t+1, so strobe-to-output latency is 2 edges.
- **Underrun pulse:** `underrun` is registered. It is asserted for the cycle following the offending strobe.
- **Enable:** `dac_out` is registered and changes only on edges where `ena` = 1.
- **No combinational paths:** nothing runs from `in_valid` to `in_ready`, or from `sample_strobe` to any output.

## Configuration
- **Macro:** `SIGDEL_UNDERRUN_CNT_EN`.
- **Defined:**
  - `underrun_count` port exists.
  - It increments on each underrun event, in the same edge that sets `underrun`.
  - It saturates at 16'hFFFF and is cleared only by `rst`.
- **Undefined:** the port and counter logic are absent. All other behaviour is identical.

## Structure
- **Package `sigdel_pkg`:**
  - default constants `SIGDEL_W` = 16 and `SIGDEL_DEPTH` = 8;
  - sample typedef `sigdel_sample_t` (logic [SIGDEL_W-1:0]).
- **Sub-module `sigdel_fifo`:**
  - synchronous FIFO, parameterised by W and DEPTH;
  - ports for push/pop, head data, level and full/empty.
- **Top-level contents:** strobe/pop control, underrun logic, the accumulator and the optional counter.

## Test plan
All scenarios use `W` = 8, `DEPTH` = 8.

- **Reset:** assert `rst` for 2 cycles.
  - Expect `dac_out` = 0, `underrun` = 0, `fifo_level` = 0, `in_ready` = 1, `underrun_count` = 0.
- **Full FIFO:** push 0x01..0x09 back-to-back with no strobes.
  - Expect `fifo_level` = 8 and `in_ready` = 0 after 8 accepted pushes; 0x09 is not accepted.
  - Strobes then pop 0x01..0x08 in order.
- **Density:** push 0x40, strobe once, hold `ena` = 1.
  - Expect exactly 64 ones on `dac_out` over any 256 consecutive cycles starting 2 cycles after the strobe.
  - Repeat with 0x00 (expect 0 ones) and 0xFF (expect 255 ones).
- **Underrun:** strobe with an empty FIFO while `cur_sample` = 0x80.
  - Expect a one-cycle `underrun` pulse, `cur_sample` still 0x80, and `underrun_count` to increment by 1.
  - Force 70000 underruns and expect `underrun_count` = 0xFFFF.
- **Simultaneous push/pop:** at `fifo_level` = 3, push and strobe in the same cycle.
  - Expect `fifo_level` to stay 3 and the pop order to be preserved.
  - Strobe while `ena` = 0 and expect no pop, no underrun, and `dac_out` frozen.
- **Mid-run reset:** assert `rst` with `fifo_level` = 5 and the modulator active.
  - Expect the FIFO empty, `dac_out` = 0 and `acc` = 0 the next cycle.
  - The next strobe must then report an underrun.
